// File: rtl/rwc_pkg.sv
// Shared definitions for the RWC challenge driver: FSM state encoding,
// default bus widths and internal counter widths.
package rwc_pkg;

    localparam int unsigned RWC_ADDR_W    = 10;
    localparam int unsigned RWC_DATA_W    = 32;
    localparam int unsigned SETTLE_CNT_W  = 4;
    localparam int unsigned TIMEOUT_CNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_SETTLE    = 3'd3,
        ST_OUTPUT    = 3'd4
    } drv_state_t;

endpackage

// File: rtl/rwc_chal_driver.sv
// Initiator side of the read-write-collision generator handshake.
// Takes a challenge over cmd_*, pulses gen_enable, follows the generator's
// available flag through its busy period, waits SETTLE_CYC cycles, then
// presents {rsp_pos, rsp_neg} and their XOR on the resp_* port.
// Optional build macro RWC_DRV_TIMEOUT_EN adds a WAIT_DONE watchdog and the
// timeout_err output.
module rwc_chal_driver
    import rwc_pkg::*;
#(
    parameter int unsigned ADDR_W      = RWC_ADDR_W,
    parameter int unsigned DATA_W      = RWC_DATA_W,
    parameter int unsigned SETTLE_CYC  = 2,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_data,
    output logic                gen_enable,
    output logic [ADDR_W-1:0]   cha_addr,
    output logic [DATA_W-1:0]   cha_data,
    input  logic                available,
    input  logic [DATA_W-1:0]   rsp_pos,
    input  logic [DATA_W-1:0]   rsp_neg,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [ADDR_W-1:0]   resp_addr,
    output logic [2*DATA_W-1:0] resp_data,
    output logic [DATA_W-1:0]   resp_flip,
    output logic                busy
`ifdef RWC_DRV_TIMEOUT_EN
    ,
    output logic                timeout_err
`endif
);

    if (SETTLE_CYC < 1 || SETTLE_CYC > 15) begin : g_bad_settle
        $error("rwc_chal_driver: SETTLE_CYC must be in 1..15");
    end
    if (TIMEOUT_CYC < 8 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
        $error("rwc_chal_driver: TIMEOUT_CYC must be in 8..65535");
    end

    drv_state_t              state, state_nx;
    logic                    ready_en;   // holds cmd_ready low until the first clock after reset
    logic                    seen_low;
    logic [SETTLE_CNT_W-1:0] settle_cnt;
    logic                    settle_last;
    logic                    accept;
    logic                    done_seen;

    assign settle_last = (settle_cnt == SETTLE_CNT_W'(SETTLE_CYC - 1));
    assign done_seen   = available & seen_low;
    assign accept      = cmd_valid & cmd_ready;

`ifdef RWC_DRV_TIMEOUT_EN
    logic [TIMEOUT_CNT_W-1:0] to_cnt;
    logic                     to_hit;
    assign to_hit      = (to_cnt == TIMEOUT_CNT_W'(TIMEOUT_CYC));
    assign timeout_err = (state == ST_WAIT_DONE) & to_hit & ~done_seen;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // Next-state and handshake decode; gen_enable depends on registered state only
    always_comb begin
        state_nx   = state;
        gen_enable = 1'b0;
        cmd_ready  = 1'b0;
        busy       = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                cmd_ready = ready_en & available & ~resp_valid;
                if (cmd_valid & cmd_ready) state_nx = ST_ISSUE;
            end
            ST_ISSUE: begin
                gen_enable = 1'b1;
                state_nx   = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (done_seen) state_nx = ST_SETTLE;
`ifdef RWC_DRV_TIMEOUT_EN
                else if (to_hit) state_nx = ST_IDLE;
`endif
            end
            ST_SETTLE: begin
                if (settle_last) state_nx = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                if (resp_ready) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Challenge latch, busy-period tracking, settle counter and response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_en   <= 1'b0;
            seen_low   <= 1'b0;
            settle_cnt <= '0;
            cha_addr   <= '0;
            cha_data   <= '0;
            resp_valid <= 1'b0;
            resp_addr  <= '0;
            resp_data  <= '0;
            resp_flip  <= '0;
        end else begin
            ready_en <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cha_addr <= cmd_addr;
                        cha_data <= cmd_data;
                    end
                end
                ST_ISSUE: begin
                    seen_low   <= 1'b0;
                    settle_cnt <= '0;
                end
                ST_WAIT_DONE: begin
                    if (!available) seen_low <= 1'b1;
                end
                ST_SETTLE: begin
                    settle_cnt <= settle_cnt + SETTLE_CNT_W'(1);
                    if (settle_last) begin
                        resp_valid <= 1'b1;
                        resp_addr  <= cha_addr;
                        resp_data  <= {rsp_pos, rsp_neg};
                        resp_flip  <= rsp_pos ^ rsp_neg;
                    end
                end
                ST_OUTPUT: begin
                    if (resp_ready) resp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef RWC_DRV_TIMEOUT_EN
    // WAIT_DONE watchdog; restarts on every issue
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        to_cnt <= '0;
        else if (state == ST_ISSUE)     to_cnt <= '0;
        else if (state == ST_WAIT_DONE) to_cnt <= to_cnt + TIMEOUT_CNT_W'(1);
    end
`endif

endmodule

// File: tb/tb_rwc_chal_driver.sv
// Directed bench for rwc_chal_driver with a small behavioural generator:
// available drops with gen_enable and returns three cycles later;
// rsp_pos = cha_data, rsp_neg = cha_data ^ cha_addr.
module tb_rwc_chal_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready;
    logic [9:0]  cmd_addr;
    logic [31:0] cmd_data;
    logic        gen_enable;
    logic [9:0]  cha_addr;
    logic [31:0] cha_data;
    logic        available;
    logic [31:0] rsp_pos, rsp_neg;
    logic        resp_valid, resp_ready;
    logic [9:0]  resp_addr;
    logic [63:0] resp_data;
    logic [31:0] resp_flip;
    logic        busy;
`ifdef RWC_DRV_TIMEOUT_EN
    logic        timeout_err;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    rwc_chal_driver #(
        .ADDR_W(10), .DATA_W(32), .SETTLE_CYC(2), .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .gen_enable(gen_enable), .cha_addr(cha_addr), .cha_data(cha_data),
        .available(available), .rsp_pos(rsp_pos), .rsp_neg(rsp_neg),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_addr(resp_addr), .resp_data(resp_data), .resp_flip(resp_flip),
        .busy(busy)
`ifdef RWC_DRV_TIMEOUT_EN
        , .timeout_err(timeout_err)
`endif
    );

    always #5 clk = ~clk;

    // Generator model
    logic [1:0] g_cnt;
    logic       force_high = 1'b0;
    logic       force_low  = 1'b0;
    always @(posedge clk or posedge rst) begin
        if (rst)             g_cnt <= 2'd0;
        else if (gen_enable) g_cnt <= 2'd2;
        else if (g_cnt != 0) g_cnt <= g_cnt - 2'd1;
    end
    assign available = force_high | (~force_low & ~gen_enable & (g_cnt == 2'd0));
    assign rsp_pos   = cha_data;
    assign rsp_neg   = cha_data ^ {22'd0, cha_addr};

    typedef struct {
        logic [9:0]  a;
        logic [63:0] d;
        logic [31:0] f;
        int          c;
    } rsp_t;

    int   gen_q[$];
    rsp_t rsp_q[$];
    int   to_q[$];
    logic [9:0]  op_addr;
    logic [31:0] op_data;
    int   cha_changes = 0;

    // Cycle counter and event monitor sampled at the active edge
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (gen_enable) begin
            gen_q.push_back(cyc);
            op_addr <= cha_addr;
            op_data <= cha_data;
        end else if (busy && (cha_addr !== op_addr || cha_data !== op_data)) begin
            cha_changes <= cha_changes + 1;
        end
        if (resp_valid && resp_ready)
            rsp_q.push_back('{a: resp_addr, d: resp_data, f: resp_flip, c: cyc});
`ifdef RWC_DRV_TIMEOUT_EN
        if (timeout_err) to_q.push_back(cyc);
`endif
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_q();
        gen_q.delete();
        rsp_q.delete();
        to_q.delete();
    endtask

    task automatic send(input logic [9:0] a, input logic [31:0] d, input bit hold, output int t);
        int k = 0;
        cmd_addr  = a;
        cmd_data  = d;
        cmd_valid = 1'b1;
        while (cmd_ready !== 1'b1 && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("cmd_accept", cmd_ready, 1'b1);
        t = cyc;
        @(negedge clk);
        if (!hold) cmd_valid = 1'b0;
    endtask

    task automatic wait_resp(input int n);
        int k = 0;
        while (rsp_q.size() < n && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("resp_arrive", rsp_q.size(), n);
    endtask

    task automatic wait_cyc(input int c);
        int k = 0;
        while (cyc < c && k < 200) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    logic [9:0]  v_addr[4] = '{10'h001, 10'h002, 10'h3FF, 10'h200};
    logic [31:0] v_data[4] = '{32'h1234_5678, 32'h0000_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    logic [31:0] v_neg[4]  = '{32'h1234_5679, 32'h0000_FFFD, 32'hFFFF_FC00, 32'h0000_0200};

    initial begin
        int t;
        int tb2[4];
        int bad;
        logic [63:0] snap_d;
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_addr   = '0;
        cmd_data   = '0;
        resp_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_gen", gen_enable, 1'b0);
        check("rst_cmd_ready", cmd_ready, 1'b0);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_cha", {cha_addr, cha_data}, '0);
        rst = 1'b0;
        #1 check("rel_cmd_ready_low", cmd_ready, 1'b0);
        @(negedge clk);
        check("rel_cmd_ready_high", cmd_ready, 1'b1);

        // 1: single operation
        clear_q();
        send(10'h155, 32'hA5A5_5A5A, 0, t);
        wait_resp(1);
        check("t1_gen_cnt", gen_q.size(), 1);
        check("t1_gen_cyc", gen_q[0], t + 1);
        check("t1_resp_cyc", rsp_q[0].c, t + 7);
        check("t1_addr", rsp_q[0].a, 10'h155);
        check("t1_data", rsp_q[0].d, 64'hA5A5_5A5A_A5A5_5B0F);
        check("t1_flip", rsp_q[0].f, 32'h0000_0155);
        @(negedge clk);
        check("t1_idle", busy, 1'b0);

        // 2: back-to-back with cmd_valid held
        clear_q();
        for (int i = 0; i < 4; i++) send(v_addr[i], v_data[i], 1, tb2[i]);
        cmd_valid = 1'b0;
        wait_resp(4);
        repeat (4) @(negedge clk);
        check("t2_gen_cnt", gen_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("t2_gen_cyc", gen_q[i], tb2[i] + 1);
            if (i > 0) check("t2_spacing", gen_q[i] - gen_q[i-1], 8);
            check("t2_addr", rsp_q[i].a, v_addr[i]);
            check("t2_data", rsp_q[i].d, {v_data[i], v_neg[i]});
            check("t2_flip", rsp_q[i].f, {22'd0, v_addr[i]});
        end
        check("t2_cha_stable", cha_changes, 0);

        // 3: backpressure
        clear_q();
        resp_ready = 1'b0;
        send(10'h0AA, 32'hDEAD_BEEF, 0, t);
        wait_cyc(t + 7);
        check("t3_valid", resp_valid, 1'b1);
        snap_d = resp_data;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (resp_valid !== 1'b1 || resp_data !== snap_d || resp_addr !== 10'h0AA ||
                resp_flip !== 32'h0000_00AA || cmd_ready !== 1'b0) bad++;
        end
        check("t3_stall_stable", bad, 0);
        check("t3_data", snap_d, 64'hDEAD_BEEF_DEAD_BE45);
        check("t3_no_extra_gen", gen_q.size(), 1);
        resp_ready = 1'b1;
        @(negedge clk);
        check("t3_one_resp", rsp_q.size(), 1);
        check("t3_valid_drop", resp_valid, 1'b0);
        check("t3_idle", busy, 1'b0);

        // 4: reset mid-operation
        clear_q();
        send(10'h321, 32'h0F0F_0F0F, 0, t);
        wait_cyc(t + 3);
        rst = 1'b1;
        #1;
        check("t4_busy", busy, 1'b0);
        check("t4_gen", gen_enable, 1'b0);
        check("t4_cmd_ready", cmd_ready, 1'b0);
        check("t4_resp", {resp_valid, resp_addr}, '0);
        check("t4_resp_data", resp_data, '0);
        check("t4_cha", {cha_addr, cha_data}, '0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("t4_no_resp", rsp_q.size(), 0);
        clear_q();
        send(10'h2A5, 32'h8000_0001, 0, t);
        wait_resp(1);
        check("t4_gen_cyc", gen_q[0], t + 1);
        check("t4_resp_cyc", rsp_q[0].c, t + 7);
        check("t4_data", rsp_q[0].d, 64'h8000_0001_8000_02A4);

        // 5: available never drops
        clear_q();
        @(negedge clk);
        force_high = 1'b1;
        send(10'h0F0, 32'h1111_1111, 0, t);
`ifdef RWC_DRV_TIMEOUT_EN
        wait_cyc(t + 18);
        check("t5_to_pulse", timeout_err, 1'b1);
        @(negedge clk);
        check("t5_to_drop", timeout_err, 1'b0);
        check("t5_cmd_ready", cmd_ready, 1'b1);
        check("t5_to_cnt", to_q.size(), 1);
        check("t5_no_resp", rsp_q.size(), 0);
`else
        repeat (40) @(negedge clk);
        check("t5_busy", busy, 1'b1);
        check("t5_no_valid", resp_valid, 1'b0);
        check("t5_no_resp", rsp_q.size(), 0);
`endif
        force_high = 1'b0;
        pulse_reset();

`ifndef RWC_DRV_TIMEOUT_EN
        // 6: generator stuck busy
        clear_q();
        send(10'h111, 32'h2222_2222, 0, t);
        force_low = 1'b1;
        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (busy !== 1'b1 || resp_valid !== 1'b0) bad++;
        end
        check("t6_stuck", bad, 0);
        force_low = 1'b0;
        pulse_reset();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule
